// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the IF-stage fetch/redirect unit.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_redirect_unit_pkg;

  localparam int unsigned PKG_XLEN     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam logic        BR_TAKEN_N   = 1'b0;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Comparator flag is active-low; jumps are always taken.
  function automatic logic br_taken(input logic branch_n, input logic jump);
    return jump | (branch_n == BR_TAKEN_N);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_redirect_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [XLEN-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,instr} holding register that absorbs a fetch returning while ID is stalled.
module fetch_skid_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            full,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out
);

  logic            full_q,  full_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Clear wins over load so a redirect never leaves a wrong-path entry behind.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full      = full_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC generator, instruction-fetch handshake FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add redirect_cnt/drop_cnt outputs.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = PKG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall_d,
  input  logic                   branch_n_d,
  input  logic                   jump_d,
  input  logic [XLEN-1:0]        target_d,
  fetch_redirect_unit_if.master  imem,
  output logic [XLEN-1:0]        pc_d,
  output logic [XLEN-1:0]        instr_d,
  output logic                   valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            redirect_cnt,
  output logic [31:0]            drop_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;

  logic            redirect;
  logic            inst_req_c;
  logic            accept;
  logic            deliver;
  logic            discard;
  logic            advance;
  logic            skid_full;
  logic            skid_load;
  logic            skid_unload;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;

  // A stalled ID stage must not redirect; the branch is re-evaluated on release.
  assign redirect = id_valid_q & ~stall_d & br_taken(branch_n_d, jump_d);
  assign advance  = ~stall_d | ~id_valid_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= FETCH_REQ;
    else       state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ: begin
        if (accept) state_d = redirect ? FETCH_DROP : FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (deliver | discard) state_d = FETCH_REQ;
        else if (redirect)     state_d = FETCH_DROP;
      end
      FETCH_DROP: begin
        if (discard) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  // FSM outputs; request is held off while the skid still owns an entry.
  always_comb begin
    inst_req_c = 1'b0;
    deliver    = 1'b0;
    discard    = 1'b0;
    case (state_q)
      FETCH_REQ:  inst_req_c = rstn & ~skid_full;
      FETCH_WAIT: begin
        deliver = imem.inst_data_ok & ~redirect;
        discard = imem.inst_data_ok &  redirect;
      end
      FETCH_DROP: discard = imem.inst_data_ok;
      default:    inst_req_c = 1'b0;
    endcase
  end

  assign accept = inst_req_c & imem.inst_addr_ok;

  // PC generation; redirect overrides the sequential increment.
  always_comb begin
    pc_f_d        = pc_f_q;
    pc_inflight_d = pc_inflight_q;
    if (accept) begin
      pc_inflight_d = pc_f_q;
      pc_f_d        = pc_f_q + XLEN'(4);
    end
    if (redirect) pc_f_d = {target_d[XLEN-1:2], 2'b00};
  end

  // IF/ID update: skid drains first, otherwise fresh data, otherwise a bubble.
  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (advance) begin
      if (skid_full) begin
        id_valid_d  = 1'b1;
        id_pc_d     = skid_pc;
        id_instr_d  = skid_instr;
        skid_unload = 1'b1;
        skid_load   = deliver;
      end else if (deliver) begin
        id_valid_d = 1'b1;
        id_pc_d    = pc_inflight_q;
        id_instr_d = imem.inst_rdata;
      end else begin
        id_valid_d = 1'b0;
      end
    end else if (deliver) begin
      skid_load = 1'b1;
    end
    if (redirect) id_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_f_q        <= RESET_PC;
      pc_inflight_q <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_instr_q    <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      pc_inflight_q <= pc_inflight_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (redirect),
    .pc_in     (pc_inflight_q),
    .instr_in  (imem.inst_rdata),
    .full      (skid_full),
    .pc_out    (skid_pc),
    .instr_out (skid_instr)
  );

  assign imem.inst_req  = inst_req_c;
  assign imem.inst_addr = pc_f_q;
  assign pc_d           = id_pc_q;
  assign instr_d        = id_instr_q;
  assign valid_d        = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] drop_cnt_q,     drop_cnt_d;

  // Event counters, free-running with natural wrap.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q + 32'(redirect);
    drop_cnt_d     = drop_cnt_q + 32'(discard);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      redirect_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

endmodule
